// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared playfield geometry and game-state encoding for the
//               pong controller and renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    // Playfield and sprite geometry in pixels
    localparam int H_VIDEO       = 640;
    localparam int V_VIDEO       = 480;
    localparam int SQUARE_WIDTH  = 16;
    localparam int PADDLE_WIDTH  = 12;
    localparam int PADDLE_HEIGHT = 96;

    // Game state encoding, also decoded by the renderer
    typedef logic [1:0] pong_state_t;

    localparam pong_state_t ST_STARTUP = 2'd0;
    localparam pong_state_t ST_SERVE   = 2'd1;
    localparam pong_state_t ST_PLAY    = 2'd2;
    localparam pong_state_t ST_OVER    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pong_ball_step.sv
`default_nettype none
// ============================================================================
// Module      : pong_ball_step
// Description : One-frame ball advance: next position, vertical direction,
//               paddle hit and miss flags. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_ball_step
    import pong_pkg::*;
#(
    parameter int H_ACTIVE = H_VIDEO,
    parameter int V_ACTIVE = V_VIDEO,
    parameter int SQ_W     = SQUARE_WIDTH,
    parameter int PAD_W    = PADDLE_WIDTH,
    parameter int PAD_H    = PADDLE_HEIGHT,
    parameter int PAD1_X   = 32,
    parameter int PAD2_X   = 596,
    parameter int SPEED    = 4
) (
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic       i_dx,       // 1 = moving right
    input  logic       i_dy,       // 1 = moving down
    input  logic [9:0] i_p1_y,
    input  logic [9:0] i_p2_y,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_dy,
    output logic       o_hit_p1,
    output logic       o_hit_p2,
    output logic       o_miss_p1,  // ball left the field past paddle 1
    output logic       o_miss_p2   // ball left the field past paddle 2
);

    // 11-bit working width keeps sums like y+side+speed from wrapping
    localparam logic [10:0] c_SPD     = 11'(SPEED);
    localparam logic [10:0] c_SQ      = 11'(SQ_W);
    localparam logic [10:0] c_PH      = 11'(PAD_H);
    localparam logic [10:0] c_H       = 11'(H_ACTIVE);
    localparam logic [10:0] c_V       = 11'(V_ACTIVE);
    localparam logic [10:0] c_P1_FACE = 11'(PAD1_X + PAD_W);
    localparam logic [10:0] c_P2X     = 11'(PAD2_X);
    localparam logic [9:0]  c_P1_REB  = 10'(PAD1_X + PAD_W + 1);
    localparam logic [9:0]  c_P2_REB  = 10'(PAD2_X - SQ_W - 1);
    localparam logic [9:0]  c_Y_BOT   = 10'(V_ACTIVE - SQ_W);

    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [10:0] w_p1_y;
    logic [10:0] w_p2_y;
    logic        w_p1_span;
    logic        w_p2_span;

    assign w_x    = {1'b0, i_x};
    assign w_y    = {1'b0, i_y};
    assign w_p1_y = {1'b0, i_p1_y};
    assign w_p2_y = {1'b0, i_p2_y};

    // Vertical overlap of ball and each paddle
    assign w_p1_span = (w_y + c_SQ >= w_p1_y) && (w_y <= w_p1_y + c_PH);
    assign w_p2_span = (w_y + c_SQ >= w_p2_y) && (w_y <= w_p2_y + c_PH);

    // Paddle contact: ball is in front of the paddle face and would reach it this frame
    assign o_hit_p1 = !i_dx && (w_x >= c_P1_FACE) && (w_x - c_SPD <= c_P1_FACE) && w_p1_span;
    assign o_hit_p2 = i_dx && (w_x + c_SQ <= c_P2X) && (w_x + c_SQ + c_SPD >= c_P2X) && w_p2_span;

    // A paddle hit takes priority over leaving the field
    assign o_miss_p1 = !i_dx && !o_hit_p1 && (w_x < c_SPD);
    assign o_miss_p2 = i_dx && !o_hit_p2 && (w_x + c_SQ + c_SPD >= c_H);

    // Vertical motion with clamp-and-reflect at top and bottom walls
    always_comb begin
        o_y  = i_y;
        o_dy = i_dy;
        if (!i_dy) begin
            if (w_y < c_SPD) begin
                o_y  = 10'd0;
                o_dy = 1'b1;
            end else begin
                o_y = 10'(w_y - c_SPD);
            end
        end else if (w_y + c_SQ + c_SPD > c_V) begin
            o_y  = c_Y_BOT;
            o_dy = 1'b0;
        end else begin
            o_y = 10'(w_y + c_SPD);
        end
    end

    // Horizontal motion; on a miss the position is left for the controller to recentre
    always_comb begin
        o_x = i_x;
        if (o_hit_p1) begin
            o_x = c_P1_REB;
        end else if (o_hit_p2) begin
            o_x = c_P2_REB;
        end else if (!o_miss_p1 && !o_miss_p2) begin
            o_x = i_dx ? 10'(w_x + c_SPD) : 10'(w_x - c_SPD);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl
// Description : Pong game sequencer: startup menu, serve delay, rally with
//               ball physics, scoring and game-over screen.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int h_video       = H_VIDEO,
    parameter int v_video       = V_VIDEO,
    parameter int square_width  = SQUARE_WIDTH,
    parameter int paddle_width  = PADDLE_WIDTH,
    parameter int paddle_height = PADDLE_HEIGHT,
    parameter int paddle1_x     = 32,
    parameter int paddle2_x     = 596,
    parameter int ball_speed    = 4,
    parameter int serve_frames  = 60,
    parameter int win_score     = 11
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       key_any,
    input  logic [9:0] paddle1_ypos,
    input  logic [9:0] paddle2_ypos,
    output logic [9:0] square_xpos,
    output logic [9:0] square_ypos,
    output logic       sq_shown,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       game_startup,
    output logic       game_over
);

    localparam logic [9:0]  c_CX       = 10'((h_video - square_width) / 2);
    localparam logic [9:0]  c_CY       = 10'((v_video - square_width) / 2);
    localparam logic [15:0] c_CNT_LAST = 16'(serve_frames - 1);
    localparam logic [3:0]  c_WIN      = 4'(win_score);

    pong_state_t r_state;
    pong_state_t w_state_nxt;
    logic [9:0]  r_x, r_y, w_x_nxt, w_y_nxt;
    logic        r_dx, r_dy, w_dx_nxt, w_dy_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [3:0]  r_s1, r_s2, w_s1_nxt, w_s2_nxt, w_s1_inc, w_s2_inc;
    logic        r_shown, r_startup, r_over;

    logic [9:0]  w_step_x, w_step_y;
    logic        w_step_dy, w_hit_p1, w_hit_p2, w_miss_p1, w_miss_p2;

    pong_ball_step #(
        .H_ACTIVE (h_video),
        .V_ACTIVE (v_video),
        .SQ_W     (square_width),
        .PAD_W    (paddle_width),
        .PAD_H    (paddle_height),
        .PAD1_X   (paddle1_x),
        .PAD2_X   (paddle2_x),
        .SPEED    (ball_speed)
    ) u_step (
        .i_x       (r_x),
        .i_y       (r_y),
        .i_dx      (r_dx),
        .i_dy      (r_dy),
        .i_p1_y    (paddle1_ypos),
        .i_p2_y    (paddle2_ypos),
        .o_x       (w_step_x),
        .o_y       (w_step_y),
        .o_dy      (w_step_dy),
        .o_hit_p1  (w_hit_p1),
        .o_hit_p2  (w_hit_p2),
        .o_miss_p1 (w_miss_p1),
        .o_miss_p2 (w_miss_p2)
    );

    // Saturating score increments
    assign w_s1_inc = (r_s1 >= c_WIN) ? c_WIN : r_s1 + 4'd1;
    assign w_s2_inc = (r_s2 >= c_WIN) ? c_WIN : r_s2 + 4'd1;

    // Next-state logic for the game FSM, ball and scores
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_dx_nxt    = r_dx;
        w_dy_nxt    = r_dy;
        w_cnt_nxt   = r_cnt;
        w_s1_nxt    = r_s1;
        w_s2_nxt    = r_s2;
        case (r_state)
            ST_STARTUP, ST_OVER: begin
                if (key_any) begin
                    w_state_nxt = ST_SERVE;
                    w_s1_nxt    = 4'd0;
                    w_s2_nxt    = 4'd0;
                    w_x_nxt     = c_CX;
                    w_y_nxt     = c_CY;
                    w_dx_nxt    = 1'b1;
                    w_dy_nxt    = 1'b1;
                    w_cnt_nxt   = 16'd0;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = ST_PLAY;
                        w_cnt_nxt   = 16'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (w_miss_p1 || w_miss_p2) begin
                        // Point scored: recentre and serve toward the player who conceded
                        w_x_nxt   = c_CX;
                        w_y_nxt   = c_CY;
                        w_dy_nxt  = 1'b1;
                        w_cnt_nxt = 16'd0;
                        if (w_miss_p1) begin
                            w_s2_nxt    = w_s2_inc;
                            w_dx_nxt    = 1'b0;
                            w_state_nxt = (w_s2_inc == c_WIN) ? ST_OVER : ST_SERVE;
                        end else begin
                            w_s1_nxt    = w_s1_inc;
                            w_dx_nxt    = 1'b1;
                            w_state_nxt = (w_s1_inc == c_WIN) ? ST_OVER : ST_SERVE;
                        end
                    end else begin
                        w_x_nxt  = w_step_x;
                        w_y_nxt  = w_step_y;
                        w_dy_nxt = w_step_dy;
                        w_dx_nxt = w_hit_p1 ? 1'b1 : (w_hit_p2 ? 1'b0 : r_dx);
                    end
                end
            end
            default: w_state_nxt = ST_STARTUP;
        endcase
    end

    // State and output registers; status flags are decoded from the next state
    always_ff @(posedge clk_0) begin
        if (rst) begin
            r_state   <= ST_STARTUP;
            r_x       <= c_CX;
            r_y       <= c_CY;
            r_dx      <= 1'b1;
            r_dy      <= 1'b1;
            r_cnt     <= 16'd0;
            r_s1      <= 4'd0;
            r_s2      <= 4'd0;
            r_startup <= 1'b1;
            r_over    <= 1'b0;
            r_shown   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_dx      <= w_dx_nxt;
            r_dy      <= w_dy_nxt;
            r_cnt     <= w_cnt_nxt;
            r_s1      <= w_s1_nxt;
            r_s2      <= w_s2_nxt;
            r_startup <= (w_state_nxt == ST_STARTUP);
            r_over    <= (w_state_nxt == ST_OVER);
            r_shown   <= (w_state_nxt == ST_PLAY);
        end
    end

    assign square_xpos  = r_x;
    assign square_ypos  = r_y;
    assign sq_shown     = r_shown;
    assign score_p1     = r_s1;
    assign score_p2     = r_s2;
    assign game_startup = r_startup;
    assign game_over    = r_over;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_game_ctrl
// Description : Self-checking bench for pong_game_ctrl with a reference game
//               model feeding an expected-value queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

    logic       clk_0 = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       key_any;
    logic [9:0] paddle1_ypos;
    logic [9:0] paddle2_ypos;
    logic [9:0] square_xpos;
    logic [9:0] square_ypos;
    logic       sq_shown;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       game_startup;
    logic       game_over;

    always #5 clk_0 = ~clk_0;

    pong_game_ctrl dut (
        .clk_0        (clk_0),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .key_any      (key_any),
        .paddle1_ypos (paddle1_ypos),
        .paddle2_ypos (paddle2_ypos),
        .square_xpos  (square_xpos),
        .square_ypos  (square_ypos),
        .sq_shown     (sq_shown),
        .score_p1     (score_p1),
        .score_p2     (score_p2),
        .game_startup (game_startup),
        .game_over    (game_over)
    );

    typedef struct {
        int x;
        int y;
        bit shown;
        bit startup;
        bit over;
        int s1;
        int s2;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state: 0 startup, 1 serve, 2 play, 3 over
    int m_state, m_x, m_y, m_dx, m_dy, m_cnt, m_s1, m_s2;
    bit p1_avoid = 1'b0;
    bit p2_avoid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int v);
        if (v < 0)   return 0;
        if (v > 384) return 384;
        return v;
    endfunction

    task automatic recentre();
        m_x = 312; m_y = 232; m_dy = 1; m_cnt = 0;
    endtask

    // One clock of the reference game
    task automatic model_step(input bit r, input bit tick, input bit key, input int p1, input int p2);
        int ny, ndy;
        bit h1, h2;
        if (r) begin
            m_state = 0; m_s1 = 0; m_s2 = 0; m_dx = 1;
            recentre();
        end else begin
            case (m_state)
                0, 3: if (key) begin
                    m_state = 1; m_s1 = 0; m_s2 = 0; m_dx = 1;
                    recentre();
                end
                1: if (tick) begin
                    m_cnt++;
                    if (m_cnt == 60) begin
                        m_state = 2;
                        m_cnt   = 0;
                    end
                end
                2: if (tick) begin
                    ny = m_y; ndy = m_dy;
                    if (m_dy == 0) begin
                        if (m_y < 4) begin ny = 0; ndy = 1; end
                        else ny = m_y - 4;
                    end else if (m_y + 20 > 480) begin
                        ny = 464; ndy = 0;
                    end else begin
                        ny = m_y + 4;
                    end
                    h1 = (m_dx == 0) && (m_x >= 44) && (m_x - 4 <= 44) && (m_y + 16 >= p1) && (m_y <= p1 + 96);
                    h2 = (m_dx == 1) && (m_x + 16 <= 596) && (m_x + 20 >= 596) && (m_y + 16 >= p2) && (m_y <= p2 + 96);
                    if (h1) begin
                        m_x = 45; m_dx = 1; m_y = ny; m_dy = ndy;
                    end else if (h2) begin
                        m_x = 579; m_dx = 0; m_y = ny; m_dy = ndy;
                    end else if (m_dx == 0 && m_x < 4) begin
                        m_s2 = (m_s2 < 11) ? m_s2 + 1 : 11;
                        m_dx = 0;
                        recentre();
                        m_state = (m_s2 == 11) ? 3 : 1;
                    end else if (m_dx == 1 && m_x + 20 >= 640) begin
                        m_s1 = (m_s1 < 11) ? m_s1 + 1 : 11;
                        m_dx = 1;
                        recentre();
                        m_state = (m_s1 == 11) ? 3 : 1;
                    end else begin
                        m_x = (m_dx == 1) ? m_x + 4 : m_x - 4;
                        m_y = ny; m_dy = ndy;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Drive one cycle, queue the model's prediction, compare after the edge
    task automatic drive(input bit r, input bit tick, input bit key);
        exp_t e;
        int   p1, p2;
        @(negedge clk_0);
        p1 = p1_avoid ? ((m_y >= 240) ? 0 : 380) : clampi(m_y - 40);
        p2 = p2_avoid ? ((m_y >= 240) ? 0 : 380) : clampi(m_y - 40);
        rst          = r;
        frame_tick   = tick;
        key_any      = key;
        paddle1_ypos = 10'(p1);
        paddle2_ypos = 10'(p2);
        model_step(r, tick, key, p1, p2);
        e.x = m_x; e.y = m_y; e.s1 = m_s1; e.s2 = m_s2;
        e.shown = (m_state == 2); e.startup = (m_state == 0); e.over = (m_state == 3);
        exp_q.push_back(e);
        @(posedge clk_0);
        #1;
        e = exp_q.pop_front();
        chk("ball_x", 32'(square_xpos), e.x);
        chk("ball_y", 32'(square_ypos), e.y);
        chk("shown", 32'(sq_shown), 32'(e.shown));
        chk("startup", 32'(game_startup), 32'(e.startup));
        chk("over", 32'(game_over), 32'(e.over));
        chk("score_p1", 32'(score_p1), e.s1);
        chk("score_p2", 32'(score_p2), e.s2);
        rst        = 1'b0;
        frame_tick = 1'b0;
        key_any    = 1'b0;
    endtask

    task automatic frame(input bit key);
        drive(1'b0, 1'b1, key);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int f;
        rst = 1'b1; frame_tick = 1'b0; key_any = 1'b0;
        paddle1_ypos = 10'd0; paddle2_ypos = 10'd0;
        m_state = 0; m_x = 312; m_y = 232; m_dx = 1; m_dy = 1; m_cnt = 0; m_s1 = 0; m_s2 = 0;

        // Reset, including reset dominating a key press
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        chk("rst_startup", 32'(game_startup), 1);
        chk("rst_x", 32'(square_xpos), 312);
        chk("rst_y", 32'(square_ypos), 232);

        // Frame ticks are ignored on the startup menu
        repeat (3) drive(1'b0, 1'b1, 1'b0);
        chk("startup_ignores_tick", 32'(game_startup), 1);

        // Key starts the serve; ball appears on the 60th tick
        drive(1'b0, 1'b0, 1'b1);
        chk("serve_entered", 32'(game_startup), 0);
        for (int i = 1; i <= 60; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            if (i == 59) chk("serve_hidden_59", 32'(sq_shown), 0);
            if (i == 60) begin
                chk("serve_shown_60", 32'(sq_shown), 1);
                chk("serve_x", 32'(square_xpos), 312);
                chk("serve_y", 32'(square_ypos), 232);
            end
            drive(1'b0, 1'b0, 1'b0);
        end

        // Rally with both paddles tracking; key presses must be ignored
        for (int i = 0; i < 300; i++) frame(i % 7 == 3);
        chk("rally_s1", 32'(score_p1), 0);
        chk("rally_s2", 32'(score_p2), 0);
        chk("rally_shown", 32'(sq_shown), 1);

        // Paddle 1 steps aside: player 2 scores
        p1_avoid = 1'b1;
        f = 0;
        while (m_state == 2 && f < 400) begin
            frame(1'b0);
            f++;
        end
        chk("p2_point_bounded", 32'(f < 400), 1);
        chk("p2_point_s2", 32'(score_p2), 1);
        chk("p2_point_shown", 32'(sq_shown), 0);
        chk("p2_point_x", 32'(square_xpos), 312);

        // Next serve heads toward player 1
        p1_avoid = 1'b0;
        repeat (60) frame(1'b0);
        frame(1'b0);
        chk("serve_dir_left", 32'(square_xpos), 308);

        // Paddle 2 keeps missing until player 1 wins
        p2_avoid = 1'b1;
        f = 0;
        while (m_state != 3 && f < 3000) begin
            frame(f % 11 == 5);
            f++;
        end
        chk("over_bounded", 32'(f < 3000), 1);
        chk("over_flag", 32'(game_over), 1);
        chk("over_s1", 32'(score_p1), 11);
        chk("over_s2", 32'(score_p2), 1);

        // Ticks ignored on the game-over screen; key restarts with cleared scores
        repeat (5) frame(1'b0);
        chk("over_hold", 32'(game_over), 1);
        drive(1'b0, 1'b0, 1'b1);
        chk("restart_over", 32'(game_over), 0);
        chk("restart_s1", 32'(score_p1), 0);
        chk("restart_s2", 32'(score_p2), 0);

        // Reset mid-rally with a coincident frame tick
        p2_avoid = 1'b0;
        repeat (60) frame(1'b0);
        repeat (20) frame(1'b0);
        chk("pre_rst_shown", 32'(sq_shown), 1);
        drive(1'b1, 1'b1, 1'b0);
        chk("midplay_rst_startup", 32'(game_startup), 1);
        chk("midplay_rst_shown", 32'(sq_shown), 0);
        chk("midplay_rst_x", 32'(square_xpos), 312);
        chk("midplay_rst_y", 32'(square_ypos), 232);
        chk("midplay_rst_s1", 32'(score_p1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
